// File: rtl/tnn_neuron_scheduler_if.sv
// Sample, configuration, shared-core and result signals of the
// ternary neuron scheduler, grouped as one bundle.
interface tnn_neuron_scheduler_if #(
    parameter int N_NEURONS = 8
);
    localparam int AW = $clog2(N_NEURONS);

    logic                 in_valid;
    logic                 in_ready;
    logic [13:0]          in_data;
    logic                 cfg_we;
    logic                 cfg_ready;
    logic [AW-1:0]        cfg_addr;
    logic [7:0]           cfg_data;
    logic [1:0]           core_a;
    logic [1:0]           core_b;
    logic [1:0]           core_c;
    logic [1:0]           core_d;
    logic [1:0]           core_e;
    logic [1:0]           core_f;
    logic [1:0]           core_g;
    logic                 core_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_NEURONS-1:0] out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, cfg_we, cfg_addr, cfg_data,
        output core_out, out_ready,
        input  in_ready, cfg_ready, out_valid, out_data, busy,
        input  core_a, core_b, core_c, core_d, core_e, core_f, core_g
    );

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_addr, cfg_data,
        input  core_out, out_ready,
        output in_ready, cfg_ready, out_valid, out_data, busy,
        output core_a, core_b, core_c, core_d, core_e, core_f, core_g
    );
endinterface

// File: rtl/tnn_neuron_scheduler.sv
// Time-multiplexes one shared ternary neuron core over N_NEURONS
// logical neurons, one decision bit per neuron per sample.
module tnn_neuron_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int CORE_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    tnn_neuron_scheduler_if.slave bus
);
    localparam int            AW    = $clog2(N_NEURONS);
    localparam logic [2:0]    CW    = 3'(CORE_WAIT);
    localparam logic [AW-1:0] KLAST = AW'(N_NEURONS - 1);
    localparam logic [AW:0]   NLIM  = (AW + 1)'(N_NEURONS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        k_q;
    logic [AW-1:0]        k_nxt;
    logic [2:0]           cnt_q;
    logic [13:0]          feat_q;
    logic [13:0]          op_q;
    logic [7:0]           cfg_q [N_NEURONS];
    logic [N_NEURONS-1:0] res_q, res_d;
    logic [N_NEURONS-1:0] out_q;
    logic                 accept;
    logic                 step;
    logic                 last;
    logic                 cfg_wr;

    // Disabled inputs are presented to the core as ternary zero.
    function automatic logic [13:0] mask_ops(
        input logic [13:0] f,
        input logic [7:0]  c
    );
        logic [13:0] m;
        m = '0;
        for (int x = 0; x < 7; x++) begin
            m[2*x +: 2] = c[x] ? f[2*x +: 2] : 2'b00;
        end
        return m;
    endfunction

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign step   = (state_q == RUN) && (cnt_q == CW);
    assign last   = (k_q == KLAST);
    assign k_nxt  = k_q + 1'b1;
    assign cfg_wr = bus.cfg_we && bus.cfg_ready
                 && ({1'b0, bus.cfg_addr} < NLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (step && last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE: bus.in_ready = 1'b1;
            RUN:  bus.busy = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cfg_ready = bus.in_ready && !bus.in_valid;

    always_comb begin
        res_d      = res_q;
        res_d[k_q] = bus.core_out ^ cfg_q[k_q][7];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            cnt_q  <= '0;
            feat_q <= '0;
            op_q   <= '0;
            res_q  <= '0;
            out_q  <= '0;
        end else if (accept) begin
            feat_q <= bus.in_data;
            op_q   <= mask_ops(bus.in_data, cfg_q[0]);
            k_q    <= '0;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            if (step) begin
                cnt_q <= '0;
                res_q <= res_d;
                if (last) begin
                    op_q  <= '0;
                    out_q <= res_d;
                end else begin
                    k_q  <= k_nxt;
                    op_q <= mask_ops(feat_q, cfg_q[k_nxt]);
                end
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cfg_q[i] <= 8'h7F;
            end
        end else if (cfg_wr) begin
            cfg_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign bus.core_a   = op_q[1:0];
    assign bus.core_b   = op_q[3:2];
    assign bus.core_c   = op_q[5:4];
    assign bus.core_d   = op_q[7:6];
    assign bus.core_e   = op_q[9:8];
    assign bus.core_f   = op_q[11:10];
    assign bus.core_g   = op_q[13:12];
    assign bus.out_data = out_q;
endmodule
